// File: rtl/demux_one_to_two_buf_pkg.sv
// rtl/demux_one_to_two_buf_pkg.sv - shared constants and helpers for the 1:2 buffered demux
package demux_one_to_two_buf_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Output channel indices; the target select and the pointer use these encodings
  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } channel_e;

  // A one-entry slot can take a word when it is empty or is being emptied this cycle
  function automatic logic slot_free(input logic valid, input logic ready);
    return (!valid) | ready;
  endfunction

endpackage

// File: rtl/demux_one_to_two_buf_out_slot.sv
// rtl/demux_one_to_two_buf_out_slot.sv - one-entry registered output slot with load and drain
module demux_out_slot
  import demux_one_to_two_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_drain;

  assign w_drain = r_valid & i_ready;

  // Load wins over drain so a slot emptied and refilled in one cycle stays valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Outputs come straight from flops; only o_free looks at the consumer's ready
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = slot_free(r_valid, i_ready);

endmodule

// File: rtl/demux_one_to_two_buf.sv
// rtl/demux_one_to_two_buf.sv - steers one valid/ready word stream into two buffered channels
module demux_one_to_two_buf
  import demux_one_to_two_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S,
  input  logic             alt_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y0,
  output logic             Y0_valid,
  input  logic             Y0_ready,
  output logic [WIDTH-1:0] Y1,
  output logic             Y1_valid,
  input  logic             Y1_ready,
  output logic             ptr
);

  logic r_ptr;
  logic w_tgt;
  logic w_free0;
  logic w_free1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Target is the alternating pointer in de-interleave mode, else the explicit select
  always_comb begin
    w_tgt = S;
    if (alt_en) begin
      w_tgt = r_ptr;
    end
  end

  // Only the targeted slot gates input; the other channel never stalls the stream
  always_comb begin
    in_ready = w_free0;
    if (w_tgt == CH1) begin
      in_ready = w_free1;
    end
  end

  assign w_accept = in_valid & in_ready;
  assign w_load0  = w_accept & (w_tgt == CH0);
  assign w_load1  = w_accept & (w_tgt == CH1);

  // Pointer advances only on accepted beats in alternating mode, so stalls keep the order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_accept && alt_en) begin
      r_ptr <= ~r_ptr;
    end
  end

  assign ptr = r_ptr;

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load0),
    .i_data  (D),
    .i_ready (Y0_ready),
    .o_data  (Y0),
    .o_valid (Y0_valid),
    .o_free  (w_free0)
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_data  (D),
    .i_ready (Y1_ready),
    .o_data  (Y1),
    .o_valid (Y1_valid),
    .o_free  (w_free1)
  );

endmodule

// File: tb/tb_demux_one_to_two_buf.sv
// tb/tb_demux_one_to_two_buf.sv - self-checking bench for the 1:2 buffered demux
module tb_demux_one_to_two_buf;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] D;
  logic         S;
  logic         alt_en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Y0;
  logic         Y0_valid;
  logic         Y0_ready;
  logic [W-1:0] Y1;
  logic         Y1_valid;
  logic         Y1_ready;
  logic         ptr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: words sitting in each channel, last word written per channel, pointer
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  logic         mptr = 1'b0;
  logic         last_acc = 1'b0;

  demux_one_to_two_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D        (D),
    .S        (S),
    .alt_en   (alt_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Y0       (Y0),
    .Y0_valid (Y0_valid),
    .Y0_ready (Y0_ready),
    .Y1       (Y1),
    .Y1_valid (Y1_valid),
    .Y1_ready (Y1_ready),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance the model
  task automatic step();
    logic tgt;
    logic rdy;
    @(negedge clk);
    tgt = alt_en ? mptr : S;
    rdy = tgt ? ((q1.size() == 0) || Y1_ready) : ((q0.size() == 0) || Y0_ready);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("Y0_valid", {31'd0, Y0_valid}, {31'd0, q0.size() != 0});
    check("Y1_valid", {31'd0, Y1_valid}, {31'd0, q1.size() != 0});
    check("Y0", {24'd0, Y0}, {24'd0, (q0.size() != 0) ? q0[0] : last0});
    check("Y1", {24'd0, Y1}, {24'd0, (q1.size() != 0) ? q1[0] : last1});
    check("ptr", {31'd0, ptr}, {31'd0, mptr});
    if ((q0.size() != 0) && Y0_ready) void'(q0.pop_front());
    if ((q1.size() != 0) && Y1_ready) void'(q1.pop_front());
    last_acc = in_valid && rdy;
    if (last_acc) begin
      if (tgt) begin
        q1.push_back(D);
        last1 = D;
      end else begin
        q0.push_back(D);
        last0 = D;
      end
      if (alt_en) mptr = ~mptr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    D = '0; S = 1'b0; alt_en = 1'b0; in_valid = 1'b0;
    Y0_ready = 1'b1; Y1_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset Y0", {24'd0, Y0}, 32'h0);
    check("reset ptr", {31'd0, ptr}, 32'h0);
    check("reset in_ready", {31'd0, in_ready}, 32'h1);
    step();

    // Explicit select
    in_valid = 1'b1; S = 1'b0; D = 8'h11;
    step();
    check("sel Y0 valid", {31'd0, Y0_valid}, 32'h1);
    check("sel Y0 data", {24'd0, Y0}, 32'h11);
    S = 1'b1; D = 8'h22;
    step();
    in_valid = 1'b0;
    check("sel Y1 valid", {31'd0, Y1_valid}, 32'h1);
    check("sel Y1 data", {24'd0, Y1}, 32'h22);
    check("sel ptr", {31'd0, ptr}, 32'h0);
    step();

    // Alternating mode, consumers always ready
    alt_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      D = 8'hA0 + 8'(i);
      step();
      check("alt dest", {24'd0, (i % 2 == 0) ? Y0 : Y1}, 32'hA0 + i);
    end
    in_valid = 1'b0;
    check("alt ptr end", {31'd0, ptr}, 32'h0);
    step();

    // Backpressure isolation on channel 1
    alt_en = 1'b0; Y1_ready = 1'b0; in_valid = 1'b1; S = 1'b1; D = 8'h31;
    step();
    D = 8'h32;
    check("bp stall", {31'd0, in_ready}, 32'h0);
    step();
    step();
    check("bp Y1 held", {24'd0, Y1}, 32'h31);
    Y1_ready = 1'b1;
    step();
    S = 1'b0; D = 8'h33;
    step();
    in_valid = 1'b0;
    check("bp Y0 data", {24'd0, Y0}, 32'h33);
    check("bp Y1 data", {24'd0, Y1}, 32'h32);
    step();

    // Alternating stall on channel 0
    alt_en = 1'b1; Y0_ready = 1'b0; in_valid = 1'b1; D = 8'h41;
    step();
    D = 8'h42;
    step();
    D = 8'h43;
    check("astall ready", {31'd0, in_ready}, 32'h0);
    check("astall ptr", {31'd0, ptr}, 32'h0);
    step();
    check("astall ptr hold", {31'd0, ptr}, 32'h0);
    Y0_ready = 1'b1;
    #1;
    check("astall release", {31'd0, in_ready}, 32'h1);
    step();
    check("astall refill v", {31'd0, Y0_valid}, 32'h1);
    check("astall refill d", {24'd0, Y0}, 32'h43);
    check("astall ptr adv", {31'd0, ptr}, 32'h1);

    // Mode switch keeps the pointer
    D = 8'h51;
    step();
    for (int i = 0; i < 3; i++) begin
      D = 8'h52 + 8'(i);
      step();
    end
    check("mode ptr", {31'd0, ptr}, 32'h1);
    alt_en = 1'b0; S = 1'b0; D = 8'h55;
    step();
    in_valid = 1'b0;
    check("mode Y0", {24'd0, Y0}, 32'h55);
    check("mode ptr kept", {31'd0, ptr}, 32'h1);
    step();

    // Randomized traffic; a stalled beat is held stable by the upstream
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        D = W'($urandom);
        S = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) alt_en = ~alt_en;
      Y0_ready = ($urandom_range(0, 2) != 0);
      Y1_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Asynchronous reset with both slots full
    in_valid = 1'b1; alt_en = 1'b1; Y0_ready = 1'b0; Y1_ready = 1'b0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mptr = 1'b0; last0 = '0; last1 = '0;
    D = 8'h61;
    step();
    D = 8'h62;
    step();
    in_valid = 1'b0;
    check("pre-rst Y0 full", {31'd0, Y0_valid}, 32'h1);
    check("pre-rst Y1 full", {31'd0, Y1_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst Y0_valid", {31'd0, Y0_valid}, 32'h0);
    check("arst Y1_valid", {31'd0, Y1_valid}, 32'h0);
    check("arst ptr", {31'd0, ptr}, 32'h0);
    check("arst Y0", {24'd0, Y0}, 32'h0);
    check("arst Y1", {24'd0, Y1}, 32'h0);
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; mptr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    Y0_ready = 1'b1; Y1_ready = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
